// File: rtl/sysid_pkg.sv
// Shared constants for the sysid checker: bus widths, word addresses, expected values, FSM encoding.
package sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1616636085;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ID_CMD  = 3'd1;
  localparam state_t ST_ID_WAIT = 3'd2;
  localparam state_t ST_TS_CMD  = 3'd3;
  localparam state_t ST_TS_WAIT = 3'd4;
  localparam state_t ST_FIN     = 3'd5;

  // Phase counter needs at least 8 bits, more if the timeout limit does not fit.
  function automatic int unsigned timer_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 1);
    return (w > 8) ? w : 8;
  endfunction

endpackage

// File: rtl/sysid_checker_if.sv
// Avalon-MM read channel between the checker (master) and the sysid slave.
interface sysid_checker_if;

  logic                                avm_address;
  logic                                avm_read;
  logic                                avm_waitrequest;
  logic                                avm_readdatavalid;
  logic [sysid_pkg::SYSID_DATA_W-1:0]  avm_readdata;

  modport master (
    output avm_address, avm_read,
    input  avm_waitrequest, avm_readdatavalid, avm_readdata
  );

  modport slave (
    input  avm_address, avm_read,
    output avm_waitrequest, avm_readdatavalid, avm_readdata
  );

endinterface

// File: rtl/phase_timer.sv
// Per-phase cycle counter; expired is registered and reflects the count currently held.
module phase_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;
  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (enable) begin
      count_nxt = count + W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_nxt;
      expired <= (count_nxt == limit - W'(1));
    end
  end

endmodule

// File: rtl/sysid_checker.sv
// Reads the sysid slave's ID and timestamp words and compares them against expected build values.
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  sysid_checker_if.master       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  id_ok,
  output logic                  ts_ok,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  localparam int unsigned CW = timer_width(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_nxt;
  logic        auto_pending;
  logic        accepted;
  logic        abort;
  logic        timer_clear;
  logic        timer_enable;
  logic        expired;
  logic        id_ok_nxt;
  logic        ts_ok_nxt;
  logic        timeout_nxt;
  logic [31:0] id_value_nxt;
  logic [31:0] ts_value_nxt;

  phase_timer #(.W(CW)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (CW'(TIMEOUT_CYCLES)),
    .expired (expired)
  );

  // Next state and next result values; the awaited event always takes priority over the timeout.
  always_comb begin
    state_nxt    = state;
    abort        = 1'b0;
    id_ok_nxt    = id_ok;
    ts_ok_nxt    = ts_ok;
    timeout_nxt  = timeout;
    id_value_nxt = id_value;
    ts_value_nxt = ts_value;
    accepted     = bus.avm_read && !bus.avm_waitrequest;

    case (state)
      ST_IDLE: begin
        if (start || auto_pending) begin
          state_nxt    = ST_ID_CMD;
          id_ok_nxt    = 1'b0;
          ts_ok_nxt    = 1'b0;
          timeout_nxt  = 1'b0;
          id_value_nxt = '0;
          ts_value_nxt = '0;
        end
      end
      ST_ID_CMD: begin
        if (accepted)     state_nxt = ST_ID_WAIT;
        else if (expired) abort = 1'b1;
      end
      ST_ID_WAIT: begin
        if (bus.avm_readdatavalid) begin
          id_value_nxt = bus.avm_readdata;
          id_ok_nxt    = (bus.avm_readdata == EXPECTED_ID);
          state_nxt    = ST_TS_CMD;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_TS_CMD: begin
        if (accepted)     state_nxt = ST_TS_WAIT;
        else if (expired) abort = 1'b1;
      end
      ST_TS_WAIT: begin
        if (bus.avm_readdatavalid) begin
          ts_value_nxt = bus.avm_readdata;
          ts_ok_nxt    = (bus.avm_readdata == EXPECTED_TS);
          state_nxt    = ST_FIN;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (abort) begin
      state_nxt   = ST_FIN;
      timeout_nxt = 1'b1;
      id_ok_nxt   = 1'b0;
      ts_ok_nxt   = 1'b0;
    end

    timer_clear  = ((state_nxt == ST_ID_CMD) && (state != ST_ID_CMD)) ||
                   ((state_nxt == ST_TS_CMD) && (state != ST_TS_CMD));
    timer_enable = (state == ST_ID_CMD) || (state == ST_ID_WAIT) ||
                   (state == ST_TS_CMD) || (state == ST_TS_WAIT);
  end

  // Bus and status outputs are registered decodes of the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= ST_IDLE;
      auto_pending    <= AUTO_START;
      bus.avm_read    <= 1'b0;
      bus.avm_address <= SYSID_ADDR_ID;
      busy            <= 1'b0;
      done            <= 1'b0;
      id_ok           <= 1'b0;
      ts_ok           <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      state           <= state_nxt;
      auto_pending    <= 1'b0;
      bus.avm_read    <= (state_nxt == ST_ID_CMD) || (state_nxt == ST_TS_CMD);
      bus.avm_address <= (state_nxt == ST_TS_CMD) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
      busy            <= (state_nxt != ST_IDLE);
      done            <= (state_nxt == ST_FIN);
      id_ok           <= id_ok_nxt;
      ts_ok           <= ts_ok_nxt;
      timeout         <= timeout_nxt;
      id_value        <= id_value_nxt;
      ts_value        <= ts_value_nxt;
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench for sysid_checker with a small Avalon-MM sysid slave model.
module tb_sysid_checker;
  import sysid_pkg::*;

  localparam logic [31:0] EXP_TS = 32'd1616636085;
  localparam int unsigned TMO    = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  sysid_checker_if bus();

  sysid_checker #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .id_ok    (id_ok),
    .ts_ok    (ts_ok),
    .timeout  (timeout),
    .id_value (id_value),
    .ts_value (ts_value)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the stimulus only)
  int          stall_cfg = 0;
  bit          mute_id   = 1'b0;
  bit          mute_ts   = 1'b0;
  logic [31:0] ts_word   = EXP_TS;
  int          stray_req = 0;

  // Slave state (written by the slave only)
  int          stray_ack = 0;
  int          id_stalled = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_data = '0;
  int          done_cnt = 0;

  // Latency-1 slave: decides waitrequest/readdatavalid away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      pend                  = 1'b0;
      id_stalled            = 0;
      stray_ack             = stray_req;
      bus.avm_waitrequest   = 1'b0;
      bus.avm_readdatavalid = 1'b0;
      bus.avm_readdata      = '0;
    end else begin
      bus.avm_readdatavalid = 1'b0;
      if (pend) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = pend_data;
        pend                  = 1'b0;
      end else if (stray_req != stray_ack) begin
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'hFFFF_FFFF;
        stray_ack             = stray_req;
      end
      bus.avm_waitrequest = 1'b0;
      if (!bus.avm_read) begin
        id_stalled = 0;
      end else if (bus.avm_address == SYSID_ADDR_ID && id_stalled < stall_cfg) begin
        bus.avm_waitrequest = 1'b1;
        id_stalled++;
      end else if ((bus.avm_address == SYSID_ADDR_ID) ? !mute_id : !mute_ts) begin
        pend      = 1'b1;
        pend_data = (bus.avm_address == SYSID_ADDR_ID) ? 32'h0000_0000 : ts_word;
      end
    end
  end

  always @(posedge clock) begin
    if (done === 1'b1) done_cnt++;
  end

  // Optionally pulse start, then count cycles until done (bounded).
  task automatic run_check(input bit pulse, input bit glitch, output int lat, output int id_rd);
    if (pulse) start = 1'b1;
    lat   = 0;
    id_rd = 0;
    do begin
      @(negedge clock);
      lat++;
      start = glitch && (lat == 2);
      if (bus.avm_read === 1'b1 && bus.avm_address === SYSID_ADDR_ID) id_rd++;
    end while (done !== 1'b1 && lat < 60);
    start = 1'b0;
  endtask

  task automatic tail(input string tag);
    @(negedge clock);
    check_eq({tag, "_done_lo"}, 32'(done), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, id_rd, d0, n;

    repeat (3) @(negedge clock);
    check_eq("rst_busy",    32'(busy),         32'd0);
    check_eq("rst_done",    32'(done),         32'd0);
    check_eq("rst_read",    32'(bus.avm_read), 32'd0);
    check_eq("rst_id_ok",   32'(id_ok),        32'd0);
    check_eq("rst_timeout", 32'(timeout),      32'd0);
    check_eq("rst_ts_val",  ts_value,          32'd0);

    // auto start after reset release
    reset = 1'b0;
    run_check(1'b0, 1'b0, lat, id_rd);
    check_eq("auto_lat",    32'(lat),     32'd5);
    check_eq("auto_id_rd",  32'(id_rd),   32'd1);
    check_eq("auto_id_ok",  32'(id_ok),   32'd1);
    check_eq("auto_ts_ok",  32'(ts_ok),   32'd1);
    check_eq("auto_tmo",    32'(timeout), 32'd0);
    check_eq("auto_id_val", id_value,     32'd0);
    check_eq("auto_ts_val", ts_value,     EXP_TS);
    tail("auto");
    check_eq("auto_held",   32'(ts_ok),   32'd1);

    // wrong timestamp
    ts_word = 32'h1234_5678;
    run_check(1'b1, 1'b0, lat, id_rd);
    check_eq("badts_lat",    32'(lat),   32'd5);
    check_eq("badts_id_ok",  32'(id_ok), 32'd1);
    check_eq("badts_ts_ok",  32'(ts_ok), 32'd0);
    check_eq("badts_ts_val", ts_value,   32'h1234_5678);
    tail("badts");
    ts_word = EXP_TS;

    // three-cycle stall on the ID command
    stall_cfg = 3;
    run_check(1'b1, 1'b0, lat, id_rd);
    check_eq("stall3_lat",   32'(lat),   32'd8);
    check_eq("stall3_id_rd", 32'(id_rd), 32'd4);
    check_eq("stall3_id_ok", 32'(id_ok), 32'd1);
    check_eq("stall3_ts_ok", 32'(ts_ok), 32'd1);
    tail("stall3");

    // acceptance on the last allowed cycle wins over the timeout
    stall_cfg = 15;
    run_check(1'b1, 1'b0, lat, id_rd);
    check_eq("stall15_lat",   32'(lat),     32'd20);
    check_eq("stall15_id_rd", 32'(id_rd),   32'd16);
    check_eq("stall15_tmo",   32'(timeout), 32'd0);
    check_eq("stall15_ts_ok", 32'(ts_ok),   32'd1);
    tail("stall15");

    // stall one cycle too long: timeout in the command phase
    stall_cfg = 16;
    run_check(1'b1, 1'b0, lat, id_rd);
    check_eq("stall16_lat",    32'(lat),     32'd17);
    check_eq("stall16_id_rd",  32'(id_rd),   32'd16);
    check_eq("stall16_tmo",    32'(timeout), 32'd1);
    check_eq("stall16_id_ok",  32'(id_ok),   32'd0);
    check_eq("stall16_ts_val", ts_value,     32'd0);
    tail("stall16");
    stall_cfg = 0;

    // no readdatavalid ever: timeout in the wait phase
    mute_id = 1'b1;
    d0 = done_cnt;
    run_check(1'b1, 1'b0, lat, id_rd);
    check_eq("mute_lat",   32'(lat),     32'd17);
    check_eq("mute_tmo",   32'(timeout), 32'd1);
    check_eq("mute_id_ok", 32'(id_ok),   32'd0);
    check_eq("mute_ts_ok", 32'(ts_ok),   32'd0);
    tail("mute");
    repeat (8) @(negedge clock);
    check_eq("mute_read_lo", 32'(bus.avm_read), 32'd0);
    check_eq("mute_one_done", 32'(done_cnt - d0), 32'd1);
    check_eq("mute_tmo_held", 32'(timeout), 32'd1);
    mute_id = 1'b0;

    // start during ID_WAIT and a stray readdatavalid in IDLE are both ignored
    d0 = done_cnt;
    run_check(1'b1, 1'b1, lat, id_rd);
    check_eq("glitch_lat",   32'(lat),     32'd5);
    check_eq("glitch_tmo",   32'(timeout), 32'd0);
    check_eq("glitch_id_ok", 32'(id_ok),   32'd1);
    tail("glitch");
    stray_req++;
    repeat (6) @(negedge clock);
    check_eq("stray_busy",    32'(busy),           32'd0);
    check_eq("stray_id_val",  id_value,            32'd0);
    check_eq("stray_ts_val",  ts_value,            EXP_TS);
    check_eq("glitch_one_done", 32'(done_cnt - d0), 32'd1);

    // reset in TS_WAIT, then auto-started fresh check
    mute_ts = 1'b1;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n = 0;
    while (!(bus.avm_read === 1'b1 && bus.avm_address === SYSID_ADDR_TS) && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq("rst_reach_ts", 32'(n < 20), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_eq("rstmid_read",  32'(bus.avm_read), 32'd0);
    check_eq("rstmid_busy",  32'(busy),         32'd0);
    check_eq("rstmid_id_ok", 32'(id_ok),        32'd0);
    @(negedge clock);
    check_eq("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
    mute_ts = 1'b0;
    reset = 1'b0;
    run_check(1'b0, 1'b0, lat, id_rd);
    check_eq("rerun_lat",   32'(lat),   32'd5);
    check_eq("rerun_id_ok", 32'(id_ok), 32'd1);
    check_eq("rerun_ts_ok", 32'(ts_ok), 32'd1);
    tail("rerun");
    check_eq("rerun_one_done", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, system ID value the checker requires at slave word 0.
REQ-002 Parameter EXPECTED_TS, default 32'd1616636085, build timestamp the checker requires at slave word 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles allowed per read phase.
REQ-004 Parameter AUTO_START, default 1, launches one check automatically after reset release.
REQ-005 The clock and reset are fixed as follows: one clock; reset is synchronous and active-high.
REQ-006 Port clock, input, 1, sole clock; all logic rising-edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port start, input, 1, single-cycle request to run a check.
REQ-009 Port avm_address, output, 1, word select to sysid slave (0 = ID, 1 = timestamp).
REQ-010 Port avm_read, output, 1, Avalon-MM read request.
REQ-011 Port avm_waitrequest, input, 1, slave stall; command accepted when avm_read=1 and avm_waitrequest=0.
REQ-012 Port avm_readdatavalid, input, 1, qualifies avm_readdata.
REQ-013 Port avm_readdata, input, 32, returned word.
REQ-014 Port busy, output, 1, high while a check runs.
REQ-015 Port done, output, 1, one-cycle pulse at check completion.
REQ-016 Port id_ok / ts_ok, output, 1 each, compare results, held until next check starts.
REQ-017 Port timeout, output, 1, sticky abort flag, held until next check starts.
REQ-018 Port id_value / ts_value, output, 32 each, captured words, held until next check starts.

Function
REQ-019 FSM states SHALL be IDLE, ID_CMD, ID_WAIT, TS_CMD, TS_WAIT, FIN.
REQ-020 IDLE -> ID_CMD on start=1; start in any non-IDLE state SHALL be ignored.
REQ-021 ID_CMD/TS_CMD SHALL drive avm_read=1 with avm_address 0/1 held stable until acceptance, then advance to ID_WAIT/TS_WAIT.
REQ-022 avm_read SHALL be 0 in all other states; at most one read outstanding.
REQ-023 Read latency is at least 1 cycle; avm_readdatavalid SHALL be honoured only in ID_WAIT/TS_WAIT and ignored elsewhere.
REQ-024 In ID_WAIT, readdatavalid SHALL capture id_value, set id_ok = (data == EXPECTED_ID), go TS_CMD.
REQ-025 In TS_WAIT, readdatavalid SHALL capture ts_value, set ts_ok = (data == EXPECTED_TS), go FIN.
REQ-026 FIN SHALL pulse done for exactly one cycle, then return to IDLE.
REQ-027 A phase counter SHALL clear on entry to each CMD state, count every cycle in CMD and WAIT, and be at least 8 bits wide or wide enough for TIMEOUT_CYCLES, whichever is larger.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1 without the awaited event, the FSM SHALL drop avm_read, set timeout=1, force id_ok=ts_ok=0, and go to FIN.
REQ-029 If the awaited event and the timeout limit occur in the same cycle, the event SHALL win.
REQ-030 Entering ID_CMD SHALL clear id_ok, ts_ok, timeout, id_value, and ts_value.
REQ-031 busy SHALL be 1 in ID_CMD through FIN inclusive.
REQ-032 Completion latency with zero waitrequest and latency-1 slave: done SHALL assert 5 cycles after the start cycle.

Reset
REQ-033 While reset=1, the block SHALL hold state IDLE, all outputs 0, and the counter 0.
REQ-034 With AUTO_START=1, the first cycle after reset deassertion SHALL behave as start=1.
REQ-035 Reset mid-check SHALL abort immediately with no done pulse; avm_read SHALL be 0 in the cycle after reset is sampled.

Structure
REQ-036 Package sysid_pkg SHALL hold the state enum, the address constants SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1, and the default EXPECTED_ID/EXPECTED_TS constants.
REQ-037 The timeout counter SHALL be a sub-module phase_timer (clear, enable, limit, expired).

Verification
REQ-038 Defaults with slave returning 0/1616636085, latency 1, no stall -> done at start+5, id_ok=1, ts_ok=1, timeout=0.
REQ-039 Slave returns ts 32'h1234_5678 -> id_ok=1, ts_ok=0, ts_value=32'h1234_5678.
REQ-040 waitrequest high 3 cycles on the ID read -> avm_read and avm_address stay stable, done at start+8, results correct.
REQ-041 readdatavalid never asserted, TIMEOUT_CYCLES=16 -> timeout=1, id_ok=ts_ok=0, single done pulse, avm_read=0 afterwards.
REQ-042 Reset asserted in TS_WAIT, then released with AUTO_START=1 -> no done before reset, fresh check completes correctly.
REQ-043 start pulsed during ID_WAIT, and stray readdatavalid in IDLE -> both ignored, exactly one done per check.
